// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stage registers.
//   ST_EMPTY/ST_ONE/ST_TWO : occupancy encodings of a two-entry skid stage
//   DATA_W                 : default data width of every stage register
package pipe_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // StBad is unreachable; it is decoded as empty so a corrupted state drains cleanly.
   typedef enum logic [1:0] {
      StEmpty = ST_EMPTY,
      StOne   = ST_ONE,
      StTwo   = ST_TWO,
      StBad   = 2'd3
   } skid_state_e;

endpackage

// File: rtl/en_reg.sv
// Data register with load enable and synchronous clear.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, q -> 0
//   clr   : synchronous clear, q -> 0 (wins over en)
//   en    : load d at the next edge
//   d     : next data
//   q     : stored data
module en_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register with a skid slot, so in_ready is
// registered and never depends combinationally on out_ready.
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous discard of all held words
//   in, in_valid        : upstream word and its valid
//   in_ready            : registered; low only while both entries are full
//   out, out_valid      : word presented downstream (always the main entry)
//   out_ready           : downstream accepts out this cycle
//   occupancy           : words held, 0..2
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       occupancy
);

   skid_state_e      state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             in_fire, out_fire;
   logic             main_ld, main_from_skid, skid_ld;
   logic [WIDTH-1:0] main_q, skid_q, main_nxt;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      unique case (state_q)
         StOne: begin
            if (in_fire && out_fire) begin
               main_ld = 1'b1;
            end else if (in_fire) begin
               state_d = StTwo;
               skid_ld = 1'b1;
            end else if (out_fire) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            // in_ready is low here, so only the drain case exists.
            if (out_fire) begin
               state_d        = StOne;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         StEmpty, StBad: begin
            if (in_fire) begin
               state_d = StOne;
               main_ld = 1'b1;
            end else begin
               state_d = StEmpty;
            end
         end
      endcase
      if (flush) begin
         state_d = StEmpty;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
      in_ready_d = (state_d != StTwo);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign main_nxt = main_from_skid ? skid_q : in;

   en_reg #(
      .WIDTH (WIDTH)
   ) u_main (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .en    (main_ld),
      .d     (main_nxt),
      .q     (main_q)
   );

   en_reg #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .en    (skid_ld),
      .d     (in),
      .q     (skid_q)
   );

   assign out       = main_q;
   assign out_valid = (state_q == StOne) || (state_q == StTwo);
   assign in_ready  = in_ready_q;
   assign occupancy = (state_q == StBad) ? ST_EMPTY : state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised self-check of pipe_skid_reg.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [31:0] in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(
      .WIDTH (32)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in        (in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [31:0] exp_out, input logic exp_ov,
                              input logic exp_ir, input logic [1:0] exp_occ);
      check({tag, ".out"}, out, exp_out);
      check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
      check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ir});
      check({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, exp_occ});
   endtask

   logic [31:0] sb[$];
   logic [31:0] bp_words[3];

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in        = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check_state("reset_init", 32'd0, 1'b0, 1'b1, 2'd0);
      step();
      step();
      reset = 1'b0;

      // Streaming at full throughput.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in       = i;
         in_valid = 1'b1;
         step();
         check_state($sformatf("stream%0d", i), i, 1'b1, 1'b1, 2'd1);
      end
      in_valid = 1'b0;
      step();
      check_state("stream_drain", 32'd0 + 32'd8, 1'b0, 1'b1, 2'd0);

      // Back-pressure: third word refused, then drain in order.
      bp_words[0] = 32'hAAAA0000;
      bp_words[1] = 32'hBBBB0000;
      bp_words[2] = 32'hCCCC0000;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in        = bp_words[0];
      step();
      check_state("bp_first", 32'hAAAA0000, 1'b1, 1'b1, 2'd1);
      in = bp_words[1];
      step();
      check_state("bp_second", 32'hAAAA0000, 1'b1, 1'b0, 2'd2);
      in = bp_words[2];
      step();
      check_state("bp_refused", 32'hAAAA0000, 1'b1, 1'b0, 2'd2);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check_state("bp_drain1", 32'hBBBB0000, 1'b1, 1'b1, 2'd1);
      step();
      check_state("bp_drain2", 32'hBBBB0000, 1'b0, 1'b1, 2'd0);

      // Full hold, then flush with a word offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in        = 32'h0000_0101;
      step();
      in = 32'h0000_0202;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_state("full_hold", 32'h0000_0101, 1'b1, 1'b0, 2'd2);
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in       = 32'hDEADBEEF;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_state("flush_full", 32'd0, 1'b0, 1'b1, 2'd0);
      out_ready = 1'b1;
      step();
      check_state("flush_after", 32'd0, 1'b0, 1'b1, 2'd0);

      // Flush while in ONE with an accepted word: word is discarded.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in        = 32'h0000_0303;
      step();
      flush = 1'b1;
      in    = 32'hDEADBEEF;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_state("flush_one", 32'd0, 1'b0, 1'b1, 2'd0);

      // Simultaneous in_fire and out_fire in ONE.
      in_valid = 1'b1;
      in       = 32'h11;
      step();
      check_state("simul_load", 32'h11, 1'b1, 1'b1, 2'd1);
      in        = 32'h22;
      out_ready = 1'b1;
      step();
      check_state("simul_swap", 32'h22, 1'b1, 1'b1, 2'd1);
      in_valid = 1'b0;
      step();
      check_state("simul_drain", 32'h22, 1'b0, 1'b1, 2'd0);

      // Asynchronous reset mid-cycle while full.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in        = 32'h0000_0404;
      step();
      in = 32'h0000_0505;
      step();
      in_valid = 1'b0;
      check_state("pre_reset_full", 32'h0000_0404, 1'b1, 1'b0, 2'd2);
      #3;
      reset = 1'b1;
      #1;
      check_state("reset_async", 32'd0, 1'b0, 1'b1, 2'd0);
      step();
      reset = 1'b0;

      // Random traffic against a FIFO scoreboard.
      for (int c = 0; c < 1000; c++) begin
         logic model_in_fire, model_out_fire;
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in        = $urandom;
         model_in_fire  = in_valid && (sb.size() < 2);
         model_out_fire = out_ready && (sb.size() > 0);
         step();
         if (model_out_fire) void'(sb.pop_front());
         if (model_in_fire) sb.push_back(in);
         check("rnd.occupancy", {30'd0, occupancy}, sb.size());
         check("rnd.out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
         check("rnd.in_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
         if (sb.size() > 0) check("rnd.out", out, sb[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
